// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
//   - opcode constants for the supported instruction classes
//   - ALUOp and ALUControl codes
//   - FSM state enum (encodings are visible on state_dbg)
//   - datapath select encodings for ALUSrcA, ALUSrcB, ResultSrc, ImmSrc
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes seen by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
//   alu_op      in  2  request from the FSM (add / sub / by funct3)
//   funct3      in  3  IR[14:12]
//   op5         in  1  IR[5]: 1 for R-type, 0 for I-type ALU ops
//   funct7b5    in  1  IR[30]
//   alu_control out 3  ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; for addi it is immediate bit 10
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the RV32I multi-cycle datapath.
//   clk, reset                 clock, async active-high reset
//   op, funct3, funct7b5, Zero instruction fields and ALU zero flag
//   PCWrite ... ALUControl     datapath enables and mux selects
//   illegal_op                 pulse in DECODE for an unsupported opcode
//   halted                     high while trapped in HALT
//   instret                    retired-instruction counter (wraps)
//   state_dbg                  current state encoding
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic                 illegal_op,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state_dbg
);

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;

    logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_op, result_src, alu_src_a, alu_src_b, imm_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            // op[5] separates sw from lw; the IR is stable for the whole instruction
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its last state.
    always_comb begin
        instret_d = instret_q;
        if (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ}) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        imm_src    = IMM_I;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                imm_src   = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_A;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                // PC <= branch target from DECODE, ALU computes OldPC+4 for rd
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                imm_src   = IMM_J;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Write enables are held off for the whole reset pulse, including the
    // part of a cycle before the state register has been forced to FETCH.
    assign PCWrite    = ~reset & (pc_update | (branch & Zero));
    assign IRWrite    = ~reset & ir_write;
    assign RegWrite   = ~reset & reg_write;
    assign MemWrite   = ~reset & mem_write;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ImmSrc     = imm_src;
    assign illegal_op = (state_q == S_DECODE) && !is_legal_op(op);
    assign halted     = (state_q == S_HALT);
    assign instret    = instret_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances share the stimulus
//   dut_a: ILLEGAL_TRAP=1, INSTRET_W=4   (trap + counter wrap)
//   dut_b: ILLEGAL_TRAP=0, INSTRET_W=32  (illegal op discarded)
// Each cycle the driver pushes the expected outputs of both instances,
// computed from instruction-level rules, and a negedge process compares.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    localparam int W = 54;  // {22-bit control vector, 32-bit instret}

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic        pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a, halt_a;
    logic [1:0]  rs_a, sa_a, sb_a, imm_a;
    logic [2:0]  alu_a;
    logic [3:0]  instret_a, st_a;
    logic        pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b, halt_b;
    logic [1:0]  rs_b, sa_b, sb_b, imm_b;
    logic [2:0]  alu_b;
    logic [31:0] instret_b;
    logic [3:0]  st_b;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int unsigned cnt_a   = 0;
    int unsigned cnt_b   = 0;

    multicycle_ctrl_fsm #(.ILLEGAL_TRAP(1'b1), .INSTRET_W(4)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
        .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a), .RegWrite(rw_a),
        .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(alu_a),
        .illegal_op(ill_a), .halted(halt_a), .instret(instret_a), .state_dbg(st_a)
    );

    multicycle_ctrl_fsm #(.ILLEGAL_TRAP(1'b0), .INSTRET_W(32)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
        .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b), .RegWrite(rw_b),
        .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(alu_b),
        .illegal_op(ill_b), .halted(halt_b), .instret(instret_b), .state_dbg(st_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic legal(input logic [6:0] o);
        return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_RTYPE) ||
               (o == OP_ITYPE) || (o == OP_BRANCH) || (o == OP_JAL);
    endfunction

    // ALU operation an R/I arithmetic instruction asks for
    function automatic logic [2:0] arith_alu(input logic [6:0] o, input logic [2:0] f, input logic f7);
        case (f)
            3'b000:  return (o == OP_RTYPE && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control vector for a given step of an instruction.
    // Layout: {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //          ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, halted}
    function automatic logic [21:0] exp_ctrl(input int st, input logic [6:0] o, input logic [2:0] f,
                                             input logic f7, input logic z, input logic rst);
        logic       pcw, adr, mw, irw, rw, ill, hlt;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic [3:0] s;
        s = rst ? 4'd0 : 4'(st);
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; hlt = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; imm = 2'b00; alu = 3'b000;
        case (s)
            4'd0:  begin irw = !rst; pcw = !rst; sb = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; imm = 2'b10; ill = !legal(o); end
            4'd2:  begin sa = 2'b10; sb = 2'b01; imm = (o == OP_STORE) ? 2'b01 : 2'b00; end
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; alu = arith_alu(o, f, f7); end
            4'd7:  begin sa = 2'b10; sb = 2'b01; alu = arith_alu(o, f, f7); end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2'b10; alu = 3'b001; pcw = z; end
            4'd10: begin sa = 2'b01; sb = 2'b10; imm = 2'b11; pcw = 1; end
            4'd11: hlt = 1;
            default: ;
        endcase
        return {s, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, hlt};
    endfunction

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            check("dut_a_cycle",
                  64'({st_a, pcw_a, adr_a, mw_a, irw_a, rw_a, rs_a, sa_a, sb_a, imm_a, alu_a,
                       ill_a, halt_a, 28'd0, instret_a}), 64'(e));
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            check("dut_b_cycle",
                  64'({st_b, pcw_b, adr_b, mw_b, irw_b, rw_b, rs_b, sa_b, sb_b, imm_b, alu_b,
                       ill_b, halt_b, instret_b}), 64'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int sa_st, input int sb_st, input logic rst);
        exp_a_q.push_back({exp_ctrl(sa_st, op, funct3, funct7b5, zero, rst), 32'(cnt_a % 16)});
        exp_b_q.push_back({exp_ctrl(sb_st, op, funct3, funct7b5, zero, rst), 32'(cnt_b)});
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic drive_cycle(input int sa_st, input int sb_st, input logic [6:0] o,
                               input logic [2:0] f, input logic f7, input logic z, input logic rst);
        op = o; funct3 = f; funct7b5 = f7; zero = z; reset = rst;
        push_exp(sa_st, sb_st, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        cnt_a = 0;
        cnt_b = 0;
        repeat (n) drive_cycle(0, 0, op, funct3, funct7b5, 1'b0, 1'b1);
    endtask

    // Zero in BEQ is zb; in every other cycle it is the opposite, so a
    // toggle outside BEQ would show up as a spurious PCWrite.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic zb);
        int seq[$];
        case (o)
            OP_LOAD:   seq = '{0, 1, 2, 3, 4};
            OP_STORE:  seq = '{0, 1, 2, 5};
            OP_RTYPE:  seq = '{0, 1, 6, 8};
            OP_ITYPE:  seq = '{0, 1, 7, 8};
            OP_BRANCH: seq = '{0, 1, 9};
            default:   seq = '{0, 1, 10, 8};
        endcase
        foreach (seq[i]) drive_cycle(seq[i], seq[i], o, f, f7, (seq[i] == 9) ? zb : !zb, 1'b0);
        cnt_a++;
        cnt_b++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ops [6];
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

        @(posedge clk);
        #1;
        check("rst_state", 64'(st_a), 64'd0);
        check("rst_instret", 64'(instret_b), 64'd0);
        check("rst_pcwrite", 64'(pcw_a), 64'd0);
        do_reset(2);

        // directed instructions (15 retire)
        run_instr(OP_LOAD,   3'b010, 1'b0, 1'b0);
        run_instr(OP_RTYPE,  3'b000, 1'b1, 1'b0);  // sub
        run_instr(OP_RTYPE,  3'b000, 1'b0, 1'b1);  // add
        run_instr(OP_ITYPE,  3'b000, 1'b1, 1'b0);  // addi with imm bit 10 set
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1);  // beq taken
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b0);  // beq not taken, Zero=1 in DECODE
        run_instr(OP_JAL,    3'b000, 1'b0, 1'b0);
        run_instr(OP_STORE,  3'b010, 1'b0, 1'b1);
        run_instr(OP_RTYPE,  3'b010, 1'b0, 1'b0);  // slt
        run_instr(OP_RTYPE,  3'b110, 1'b0, 1'b0);  // or
        run_instr(OP_RTYPE,  3'b111, 1'b1, 1'b0);  // and
        run_instr(OP_ITYPE,  3'b111, 1'b0, 1'b0);  // andi
        run_instr(OP_ITYPE,  3'b110, 1'b0, 1'b0);  // ori
        run_instr(OP_ITYPE,  3'b010, 1'b1, 1'b0);  // slti
        run_instr(OP_RTYPE,  3'b001, 1'b1, 1'b0);  // unlisted funct3 -> add
        check("lit_instret_b_15", 64'(instret_b), 64'd15);
        check("lit_instret_a_15", 64'(instret_a), 64'd15);

        // random legal instructions
        repeat (120) begin
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // illegal opcode: dut_a traps, dut_b keeps discarding it
        drive_cycle(0, 0, 7'b1111111, 3'd0, 1'b1, 1'b1, 1'b0);
        drive_cycle(1, 1, 7'b1111111, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(11, (i % 2 == 0) ? 0 : 1, 7'b1111111, 3'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("lit_halted_a", 64'(halt_a), 64'd1);
        check("lit_state_a_halt", 64'(st_a), 64'd11);
        check("lit_halted_b", 64'(halt_b), 64'd0);

        // reset out of HALT, retire one lw, then abort a sw in MEMWRITE
        do_reset(2);
        run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0);
        drive_cycle(0, 0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        drive_cycle(1, 1, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        drive_cycle(2, 2, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
        push_exp(5, 5, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("lit_midrst_state", 64'(st_a), 64'd0);
        check("lit_midrst_memwrite", 64'(mw_a), 64'd0);
        check("lit_midrst_instret", 64'(instret_b), 64'd0);
        @(posedge clk);
        #1;
        do_reset(1);

        // counter wrap on the 4-bit instance
        repeat (15) run_instr(OP_RTYPE, 3'b000, 1'b0, 1'b0);
        check("lit_wrap_15", 64'(instret_a), 64'd15);
        run_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0);
        check("lit_wrap_0", 64'(instret_a), 64'd0);
        check("lit_wrap_b_16", 64'(instret_b), 64'd16);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I subset datapath: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Moore FSM sequences a shared ALU/memory datapath over 3–5 cycles per instruction. It drives mux selects, register enables and ALUControl.
- Sits beside the multi-cycle datapath, which provides the PC, OldPC, IR, Data, ALUOut and A/B registers.
- Also provides an illegal-opcode trap and a retired-instruction counter for debug.

Parameters:
- ILLEGAL_TRAP, 1: 1 = an illegal opcode enters HALT until reset; 0 = an illegal opcode is discarded and the FSM returns to FETCH.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH, clears the counter and flags.
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag, combinational, same cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data-memory write enable
- IRWrite  out  1  IR/OldPC enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A (rs1)
- ALUSrcB  out  2  00 = B (rs2), 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- halted  out  1  high while in HALT
- instret  out  INSTRET_W  retired-instruction count, wraps modulo 2^INSTRET_W
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH(0), DECODE(1), MEMADR(2), MEMREAD(3), MEMWB(4), MEMWRITE(5), EXECR(6), EXECI(7), ALUWB(8), BEQ(9), JAL(10), HALT(11).
- Transitions:
  - FETCH → DECODE.
  - DECODE by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other op → HALT (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0).
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
  - HALT → HALT.
- Outputs are decoded from state only, except PCWrite = PCUpdate | (Branch & Zero). Any select not listed for a state is 00/0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUOp=00. This computes the branch target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=00 (lw) or 01 (sw).
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, ImmSrc=11, PCUpdate=1.
  - HALT: all enables 0.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000: sub iff {op[5], funct7b5} == 11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: add.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3 (taken or not).
- instret:
  - Increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ.
  - Does not increment for illegal opcodes.
  - Wraps from all-ones to 0.
- Reset:
  - While reset is high, state = FETCH, instret = 0, illegal_op = 0 and halted = 0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; the other selects show FETCH values.
  - Reset asserted mid-instruction aborts the instruction with no partial writes after the reset edge.
  - Deassertion: FETCH begins on the first rising edge after reset falls.
- Zero is sampled only in BEQ. Changes on Zero in any other state have no effect.
- HALT is left only by reset.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - ALUControl codes;
  - the state enum;
  - encodings for ALUSrcA, ALUSrcB, ResultSrc and ImmSrc.
- One combinational sub-module, alu_decoder (inputs ALUOp, funct3, op5, funct7b5; output ALUControl), instantiated once. The FSM and output decode stay in multicycle_ctrl_fsm.

Test Plan:
- Reset mid-MEMWRITE: assert reset while in state 5 → state_dbg=0 immediately, MemWrite=0, instret=0; FETCH begins after deassertion.
- lw (op=0000011): states 0→1→2→3→4→0 over 5 cycles; MemWrite=0 throughout; RegWrite=1 only in MEMWB with ResultSrc=01; instret +1.
- sub (op=0110011, funct3=000, funct7b5=1): EXECR shows ALUControl=001; the same with funct7b5=0 gives 000; addi (op=0010011, funct7b5=1) gives 000.
- beq with Zero=1 in BEQ → PCWrite=1 for exactly that cycle; with Zero=0 → PCWrite=0; Zero toggled during DECODE causes no PCWrite; 3 cycles each.
- Illegal op 7'b1111111, ILLEGAL_TRAP=1 → illegal_op pulses in DECODE, then halted=1, state_dbg=11, all enables 0 for 20 cycles, instret unchanged; ILLEGAL_TRAP=0 → back to FETCH next cycle, halted stays 0.
- INSTRET_W=4: retire 16 R-type instructions → instret wraps from 15 to 0; jal sequence 0→1→10→8→0 with ImmSrc=11 and PCWrite=1 in JAL.
